// File: rtl/blood_ph_sampler.sv
// blood_ph_sampler
// Receives serial pH frames from the blood sensor and publishes a 4-sample
// averaged pH value.
// Frame format, one bit per bitStrobe cycle:
//   start 0, 4 data bits MSB first, even parity bit, stop 1.
// Good frames are clamped to PH_MAX and accumulated. Every 4th good frame
// loads bloodPH with the truncated average and pulses phValid. Bad frames
// pulse frameError and bump a saturating errorCount.
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   bitStrobe  one-cycle qualifier for sensorData
//   sensorData serial sensor line (idles high)
//   bloodPH    averaged pH value (registered, holds between updates)
//   phValid    one-cycle pulse: new bloodPH value
//   frameError one-cycle pulse: frame rejected
//   errorCount saturating count of rejected frames
module blood_ph_sampler #(
  parameter int PH_MAX = 14
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bitStrobe,
  input  logic       sensorData,
  output logic [3:0] bloodPH,
  output logic       phValid,
  output logic       frameError,
  output logic [7:0] errorCount
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam logic [3:0] PH_MAX_4 = 4'(PH_MAX);

  // Even parity: data bits XOR parity bit must be zero.
  function automatic logic parity_ok(input logic [3:0] data, input logic par);
    return ((^data) ^ par) == 1'b0;
  endfunction

  // Limit a decoded sample to the physiological maximum.
  function automatic logic [3:0] clamp_ph(input logic [3:0] data);
    return (data > PH_MAX_4) ? PH_MAX_4 : data;
  endfunction

  state_t      state_r,      state_s;
  logic [1:0]  bit_cnt_r,    bit_cnt_s;
  logic [3:0]  shift_r,      shift_s;
  logic        par_r,        par_s;
  logic [5:0]  acc_r,        acc_s;
  logic [1:0]  cnt_r,        cnt_s;
  logic [3:0]  ph_s;
  logic        ph_valid_s;
  logic        frame_err_s;
  logic [7:0]  err_cnt_s;
  logic [5:0]  sum_s;

  // Accumulator plus the current clamped sample; at most 3*14+14 = 56, fits 6 bits.
  assign sum_s = acc_r + {2'b00, clamp_ph(shift_r)};

  // Next-state and datapath decisions; everything holds unless bitStrobe=1.
  always_comb begin
    state_s     = state_r;
    bit_cnt_s   = bit_cnt_r;
    shift_s     = shift_r;
    par_s       = par_r;
    acc_s       = acc_r;
    cnt_s       = cnt_r;
    ph_s        = bloodPH;
    ph_valid_s  = 1'b0;
    frame_err_s = 1'b0;
    err_cnt_s   = errorCount;
    if (bitStrobe) begin
      case (state_r)
        IDLE: begin
          if (!sensorData) begin
            state_s   = DATA;
            bit_cnt_s = 2'd0;
          end else begin
            state_s = IDLE;
          end
        end
        DATA: begin
          shift_s = {shift_r[2:0], sensorData};
          if (bit_cnt_r == 2'd3) begin
            state_s   = PARITY;
            bit_cnt_s = 2'd0;
          end else begin
            bit_cnt_s = bit_cnt_r + 2'd1;
          end
        end
        PARITY: begin
          par_s   = sensorData;
          state_s = STOP;
        end
        STOP: begin
          state_s = IDLE;
          if (sensorData && parity_ok(shift_r, par_r)) begin
            if (cnt_r == 2'd3) begin
              ph_s       = sum_s[5:2];
              ph_valid_s = 1'b1;
              acc_s      = 6'd0;
              cnt_s      = 2'd0;
            end else begin
              acc_s = sum_s;
              cnt_s = cnt_r + 2'd1;
            end
          end else begin
            frame_err_s = 1'b1;
            if (errorCount != 8'hFF) begin
              err_cnt_s = errorCount + 8'd1;
            end else begin
              err_cnt_s = errorCount;
            end
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State and output registers; reset discards any partial frame and samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      bit_cnt_r  <= 2'd0;
      shift_r    <= 4'd0;
      par_r      <= 1'b0;
      acc_r      <= 6'd0;
      cnt_r      <= 2'd0;
      bloodPH    <= 4'd0;
      phValid    <= 1'b0;
      frameError <= 1'b0;
      errorCount <= 8'd0;
    end else begin
      state_r    <= state_s;
      bit_cnt_r  <= bit_cnt_s;
      shift_r    <= shift_s;
      par_r      <= par_s;
      acc_r      <= acc_s;
      cnt_r      <= cnt_s;
      bloodPH    <= ph_s;
      phValid    <= ph_valid_s;
      frameError <= frame_err_s;
      errorCount <= err_cnt_s;
    end
  end

endmodule

// File: tb/tb_blood_ph_sampler.sv
// Testbench for blood_ph_sampler: table of frames with expected bloodPH and
// errorCount, plus a pulse scoreboard filled by a reference model as frames
// are driven and drained when phValid/frameError pulses appear.
module tb_blood_ph_sampler;

  logic       clk = 1'b0;
  logic       reset;
  logic       bitStrobe;
  logic       sensorData;
  logic [3:0] bloodPH;
  logic       phValid;
  logic       frameError;
  logic [7:0] errorCount;

  int checks = 0;
  int errors = 0;

  blood_ph_sampler #(.PH_MAX(14)) dut (
    .clk        (clk),
    .reset      (reset),
    .bitStrobe  (bitStrobe),
    .sensorData (sensorData),
    .bloodPH    (bloodPH),
    .phValid    (phValid),
    .frameError (frameError),
    .errorCount (errorCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] data;
    bit         par_ok;
    bit         stop;
    logic [3:0] exp_ph;
    logic [7:0] exp_err;
  } vec_t;

  typedef struct {
    bit         is_err;
    logic [3:0] ph;
    logic [7:0] ec;
  } ev_t;

  vec_t tbl[18];
  ev_t  sbq[$];

  // Reference model state
  int         macc;
  int         mcnt;
  int         merr;
  logic [3:0] mph;

  function automatic vec_t mk(input logic [3:0] d, input bit p, input bit s,
                              input logic [3:0] eph, input logic [7:0] eerr);
    vec_t v;
    v.data = d; v.par_ok = p; v.stop = s; v.exp_ph = eph; v.exp_err = eerr;
    return v;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Pulse monitor: every pulse cycle must match the head of the scoreboard.
  always @(negedge clk) begin
    ev_t e;
    if (!reset) begin
      if (phValid && frameError) begin
        checks++; errors++;
        $display("FAIL pulse_overlap: got phValid=1 frameError=1 expected never both");
      end else if (phValid || frameError) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pulse: got phValid=%0d frameError=%0d expected none",
                   phValid, frameError);
        end else begin
          e = sbq.pop_front();
          check("pulse_kind_err", int'(frameError), int'(e.is_err));
          check("pulse_bloodPH", int'(bloodPH), int'(e.ph));
          check("pulse_errorCount", int'(errorCount), int'(e.ec));
        end
      end
    end
  end

  function automatic int pick_gap(input int gmax);
    return (gmax == 0) ? 0 : int'($urandom_range(gmax, 1));
  endfunction

  task automatic drive_bit(input logic b, input int gap);
    repeat (gap) begin
      @(posedge clk); #1;
      bitStrobe  = 1'b0;
      sensorData = 1'($urandom);
    end
    @(posedge clk); #1;
    bitStrobe  = 1'b1;
    sensorData = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bitStrobe  = 1'b0;
      sensorData = 1'b1;
    end
  endtask

  task automatic model_clear();
    macc = 0; mcnt = 0; merr = 0; mph = 4'd0;
    sbq.delete();
  endtask

  task automatic send_frame(input logic [3:0] d, input bit par_ok, input bit stop, input int gmax);
    logic p;
    int   c;
    ev_t  e;
    p = par_ok ? (^d) : ~(^d);
    if (stop && par_ok) begin
      c = (d > 4'd14) ? 14 : int'(d);
      if (mcnt == 3) begin
        mph = 4'((macc + c) >> 2);
        macc = 0; mcnt = 0;
        e.is_err = 1'b0; e.ph = mph; e.ec = 8'(merr);
        sbq.push_back(e);
      end else begin
        macc += c; mcnt++;
      end
    end else begin
      if (merr < 255) merr++;
      e.is_err = 1'b1; e.ph = mph; e.ec = 8'(merr);
      sbq.push_back(e);
    end
    drive_bit(1'b0, pick_gap(gmax));
    for (int i = 3; i >= 0; i--) drive_bit(d[i], pick_gap(gmax));
    drive_bit(p, pick_gap(gmax));
    drive_bit(stop, pick_gap(gmax));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; bitStrobe = 1'b0; sensorData = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    model_clear();
  endtask

  task automatic run_table(input int gmax);
    for (int i = 0; i < 18; i++) begin
      send_frame(tbl[i].data, tbl[i].par_ok, tbl[i].stop, gmax);
      idle(2);
      @(negedge clk);
      check($sformatf("tbl%0d_bloodPH", i), int'(bloodPH), int'(tbl[i].exp_ph));
      check($sformatf("tbl%0d_errorCount", i), int'(errorCount), int'(tbl[i].exp_err));
      check($sformatf("tbl%0d_pending", i), sbq.size(), 0);
    end
  endtask

  initial begin
    // 7 x4 -> 7; 7,7,10,10 -> 8; 15 x4 -> 14; 10, bad 10, 10,10,10 -> 10; stop=0
    tbl[0]  = mk(4'd7,  1'b1, 1'b1, 4'd0,  8'd0);
    tbl[1]  = mk(4'd7,  1'b1, 1'b1, 4'd0,  8'd0);
    tbl[2]  = mk(4'd7,  1'b1, 1'b1, 4'd0,  8'd0);
    tbl[3]  = mk(4'd7,  1'b1, 1'b1, 4'd7,  8'd0);
    tbl[4]  = mk(4'd7,  1'b1, 1'b1, 4'd7,  8'd0);
    tbl[5]  = mk(4'd7,  1'b1, 1'b1, 4'd7,  8'd0);
    tbl[6]  = mk(4'd10, 1'b1, 1'b1, 4'd7,  8'd0);
    tbl[7]  = mk(4'd10, 1'b1, 1'b1, 4'd8,  8'd0);
    tbl[8]  = mk(4'd15, 1'b1, 1'b1, 4'd8,  8'd0);
    tbl[9]  = mk(4'd15, 1'b1, 1'b1, 4'd8,  8'd0);
    tbl[10] = mk(4'd15, 1'b1, 1'b1, 4'd8,  8'd0);
    tbl[11] = mk(4'd15, 1'b1, 1'b1, 4'd14, 8'd0);
    tbl[12] = mk(4'd10, 1'b1, 1'b1, 4'd14, 8'd0);
    tbl[13] = mk(4'd10, 1'b0, 1'b1, 4'd14, 8'd1);
    tbl[14] = mk(4'd10, 1'b1, 1'b1, 4'd14, 8'd1);
    tbl[15] = mk(4'd10, 1'b1, 1'b1, 4'd14, 8'd1);
    tbl[16] = mk(4'd10, 1'b1, 1'b1, 4'd10, 8'd1);
    tbl[17] = mk(4'd5,  1'b1, 1'b0, 4'd10, 8'd2);

    reset = 1'b1; bitStrobe = 1'b0; sensorData = 1'b1;
    model_clear();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Quiet line after reset: all outputs stay zero.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("reset_quiet", int'({bloodPH, phValid, frameError, errorCount}), 0);
    end

    run_table(0);
    do_reset();
    run_table(5);

    // 300 back-to-back bad frames saturate errorCount.
    for (int i = 0; i < 300; i++) send_frame(4'(i), 1'b1, 1'b0, 0);
    idle(3);
    @(negedge clk);
    check("err_saturate", int'(errorCount), 255);
    check("err_sat_pending", sbq.size(), 0);

    // Reset mid-frame discards partial frame and accumulated samples.
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      @(negedge clk);
      check("mid_reset_ph0", int'(bloodPH), 0);
      check("mid_reset_err0", int'(errorCount), 0);
      send_frame(4'd12, 1'b1, 1'b1, pass * 5);
      send_frame(4'd12, 1'b1, 1'b1, pass * 5);
      drive_bit(1'b0, pick_gap(pass * 5));
      drive_bit(1'b1, pick_gap(pass * 5));
      drive_bit(1'b1, pick_gap(pass * 5));
      do_reset();
      for (int i = 0; i < 4; i++) send_frame(4'd3, 1'b1, 1'b1, pass * 5);
      idle(3);
      @(negedge clk);
      check("after_reset_ph", int'(bloodPH), 3);
      check("after_reset_err", int'(errorCount), 0);
      check("after_reset_pending", sbq.size(), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/blood_ph_sampler.md
BLOOD_PH_SAMPLER -- requirements
Module: blood_ph_sampler

Interface
REQ-001 Parameter PH_MAX, default 14: upper clamp for any decoded pH sample.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 bitStrobe  input  1  one-cycle qualifier; sensorData is sampled only on cycles where bitStrobe=1.
REQ-005 sensorData  input  1  serial line from the pH sensor; idles high.
REQ-006 bloodPH  output  4  averaged pH value; feeds the pH analyzer's bloodPH input.
REQ-007 phValid  output  1  one-cycle pulse marking a new bloodPH value.
REQ-008 frameError  output  1  one-cycle pulse marking a rejected frame.
REQ-009 errorCount  output  8  saturating count of rejected frames.

Function
REQ-010 Frame format SHALL be: start bit 0, 4 data bits MSB first, 1 even-parity bit, stop bit 1; one bit per bitStrobe cycle.
REQ-011 The FSM SHALL have states IDLE, DATA, PARITY, STOP and SHALL advance only on bitStrobe=1 cycles; with bitStrobe=0 it holds.
REQ-012 IDLE -> DATA when bitStrobe=1 and sensorData=0; otherwise it stays in IDLE.
REQ-013 DATA shifts in exactly 4 bits (bit counter 0..3), then moves to PARITY.
REQ-014 PARITY captures one bit, then moves to STOP.
REQ-015 STOP captures one bit, then returns to IDLE unconditionally.
REQ-016 A frame is good when stop=1 and the XOR of the 4 data bits and the parity bit is 0.
REQ-017 A good frame's data value SHALL be clamped to PH_MAX when above it (15 -> 14), then added to a 6-bit accumulator, and the 2-bit sample count SHALL be incremented.
REQ-018 A bad frame SHALL be discarded without touching the accumulator or sample count.
REQ-019 For a bad frame, frameError SHALL be 1 for exactly the cycle after the edge that sampled the stop bit.
REQ-020 For a bad frame, errorCount SHALL increment on that same edge, saturating at 255.
REQ-021 When the 4th good frame's stop bit is sampled, bloodPH SHALL load (accumulator + clamped sample) >> 2, truncated, on that edge.
REQ-022 On that same edge, phValid SHALL be set for exactly one cycle.
REQ-023 On that same edge, the accumulator and sample count SHALL clear.
REQ-024 bloodPH SHALL hold its last value between updates.
REQ-025 phValid and frameError SHALL never be asserted in the same cycle.
REQ-026 A new start bit is accepted on the first bitStrobe cycle after STOP; back-to-back frames SHALL lose no bits.
REQ-027 sensorData values on bitStrobe=0 cycles SHALL have no effect.

Reset
REQ-028 While reset=1: FSM in IDLE; bit counter, accumulator and sample count 0; bloodPH=0, phValid=0, frameError=0, errorCount=0.
REQ-029 Reset SHALL take priority over bitStrobe.
REQ-030 Reset asserted mid-frame SHALL abandon the partial frame and all accumulated samples, with no phValid or frameError pulse.

Verification
REQ-031 Reset with sensorData=1 and no strobes -> all outputs 0 and remain 0 for 20 cycles.
REQ-032 Four good frames of value 7 (0111, parity 1) -> bloodPH=7 and one phValid pulse after the 4th stop bit; no frameError.
REQ-033 Good frames 7, 7, 10, 10 (1010, parity 0) -> sum 34 -> bloodPH=8 and a single phValid pulse.
REQ-034 Four good frames of 15 (1111, parity 0) -> each clamped to 14 -> bloodPH=14.
REQ-035 Good 10, then 10 with wrong parity, then good 10, 10, 10 -> one frameError pulse, errorCount=1, then bloodPH=10 after the 5th frame; plus a stop-bit=0 frame -> errorCount=2; 300 bad frames -> errorCount=255.
REQ-036 Two good frames of 12, then a frame cut after 2 data bits by reset, then four good frames of 3 -> no pulses before reset, then bloodPH=3; irregular bitStrobe spacing (1-5 idle cycles) -> same results.
